// File: rtl/key_debounce_irq.sv
// Debounced, interrupt-capable front end for the 8 user keys (synchroniser, debouncer, sticky PEND, MASK).
// Optional KEY_RELEASE_IRQ_EN: releases also raise PEND, and offset 0xC exposes the EDGE register.
module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key,
  output logic acc,
  output logic acc_val
);
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_q, key_d;

  always_comb begin
    sync_d  = {sync_q[0], key_in};
    cnt_d   = cnt_q;
    key_d   = key_q;
    acc     = 1'b0;
    acc_val = sync_q[1];
    if (sync_q[1] == key_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      // the DEBOUNCE_CYCLES-th consecutive differing sample accepts the new level
      key_d = sync_q[1];
      cnt_d = '0;
      acc   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      key_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      key_q  <= key_d;
    end
  end

  assign key = key_q;
endmodule

module key_debounce_irq #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic        clk,
  input  logic        sys_rstn,
  input  logic [7:0]  user_key,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  localparam int NUM_KEYS = 8;

  logic [NUM_KEYS-1:0] key_in, key, acc, acc_val, press, ev;
  logic [NUM_KEYS-1:0] pend_q, pend_d, mask_q, mask_d, clr;
  logic                unused_wdata;

  assign key_in = ACTIVE_LOW ? ~user_key : user_key;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_lane
      key_debounce_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
        .clk    (clk),
        .rst_n  (sys_rstn),
        .key_in (key_in[gi]),
        .key    (key[gi]),
        .acc    (acc[gi]),
        .acc_val(acc_val[gi])
      );
    end
  endgenerate

  assign press = acc & acc_val;

`ifdef KEY_RELEASE_IRQ_EN
  logic [NUM_KEYS-1:0] edge_q, edge_d;
  assign ev = acc;
  // EDGE tracks the direction of the most recent accepted transition per key
  always_comb edge_d = (edge_q & ~acc) | press;
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) edge_q <= '0;
    else           edge_q <= edge_d;
  end
`else
  assign ev = press;
`endif

  always_comb begin
    clr    = (we && addr == 2'd1) ? wdata[NUM_KEYS-1:0] : '0;
    // a new event on the same edge as its W1C keeps the bit set
    pend_d = (pend_q & ~clr) | ev;
    mask_d = (we && addr == 2'd2) ? wdata[NUM_KEYS-1:0] : mask_q;
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata = {24'b0, key};
      2'd1: rdata = {24'b0, pend_q};
      2'd2: rdata = {24'b0, mask_q};
`ifdef KEY_RELEASE_IRQ_EN
      2'd3: rdata = {24'b0, edge_q};
`endif
      default: rdata = '0;
    endcase
  end

  assign irq          = |(pend_q & mask_q);
  assign unused_wdata = &{1'b0, wdata[31:8]};
endmodule
